// File: rtl/firtap_loader_if.sv
// rtl/firtap_loader_if.sv - coefficient stream interface for the FIR tap loader
// Carries the valid/ready coefficient stream from the producer into the loader.
interface firtap_loader_if #(
  parameter int TW = 16
);
  logic          s_valid;
  logic          s_ready;
  logic [TW-1:0] s_tap;

  modport master (output s_valid, output s_tap, input s_ready);
  modport slave  (input s_valid, input s_tap, output s_ready);
endinterface

// File: rtl/firtap_loader.sv
// rtl/firtap_loader.sv - shifts streamed coefficients or zeros into an adjustable FIR tap chain
// The filter clock-enable is held off whenever the chain is only partly written.
module firtap_loader #(
  parameter int TW      = 16,
  parameter int NTAPS   = 128,
  parameter int LGNTAPS = 7
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_start,
  input  logic            i_clear,
  firtap_loader_if.slave  strm,
  output logic            o_tap_wr,
  output logic [TW-1:0]   o_tap,
  output logic            o_ce_hold,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [LGNTAPS-1:0] LAST = LGNTAPS'(NTAPS - 1);

  state_t              state_q, state_d;
  logic [LGNTAPS-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]       tap_q, tap_d;
  logic                tap_wr_q, tap_wr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [LGNTAPS-1:0]  cnt_base;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tap_q    <= '0;
      tap_wr_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tap_q    <= tap_d;
      tap_wr_q <= tap_wr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tap_d    = tap_q;
    tap_wr_d = 1'b0;
    err_d    = 1'b0;
    cnt_base = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (i_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (i_clear) begin
          err_d   = 1'b1;
          state_d = CLEAR;
          cnt_d   = '0;
        end else begin
          // A restart rewinds the count but still takes this cycle's coefficient as the first.
          if (i_start) begin
            err_d    = 1'b1;
            cnt_base = '0;
          end
          cnt_d = cnt_base;
          if (strm.s_valid) begin
            tap_d    = strm.s_tap;
            tap_wr_d = 1'b1;
            cnt_d    = cnt_base + 1'b1;
            if (cnt_base == LAST) begin
              state_d = DONE;
            end
          end
        end
      end
      CLEAR: begin
        tap_d    = '0;
        tap_wr_d = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign strm.s_ready = (state_q == LOAD);
  assign o_tap_wr     = tap_wr_q;
  assign o_tap        = tap_q;
  assign o_busy       = busy_q;
  assign o_ce_hold    = busy_q;
  assign o_done       = done_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_firtap_loader.sv
// tb/tb_firtap_loader.sv - self-checking bench for firtap_loader with a 4-tap chain
// Per-cycle behavioural model plus a shadow shift-register of the tap chain.
module tb_firtap_loader;
  localparam int TW      = 16;
  localparam int NTAPS   = 4;
  localparam int LGNTAPS = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic          tap_wr;
  logic [TW-1:0] tap;
  logic          ce_hold, busy, done, err;

  firtap_loader_if #(.TW(TW)) strm_if ();

  firtap_loader #(.TW(TW), .NTAPS(NTAPS), .LGNTAPS(LGNTAPS)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_start   (start),
    .i_clear   (clear),
    .strm      (strm_if),
    .o_tap_wr  (tap_wr),
    .o_tap     (tap),
    .o_ce_hold (ce_hold),
    .o_busy    (busy),
    .o_done    (done),
    .o_err     (err)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_LOAD, M_CLEAR, M_DONE} mode_t;

  int            n_cmp = 0;
  int            n_fail = 0;
  string         tag = "init";
  mode_t         m_mode = M_IDLE;
  int            m_cnt = 0;
  logic [TW-1:0] m_tap = '0;
  logic [TW-1:0] obs_q[$];
  logic [TW-1:0] sent_q[$];
  logic [TW-1:0] chain[NTAPS];

  // One clock of stimulus; expectations come from the loader's behavioural rules.
  task automatic step(input logic st, input logic cl, input logic v, input logic [TW-1:0] d);
    logic          e_wr, e_err;
    logic [TW-1:0] e_tap;
    mode_t         nm;
    start = st; clear = cl; strm_if.s_valid = v; strm_if.s_tap = d;
    #1;
    n_cmp++;
    if (strm_if.s_ready !== 1'(m_mode == M_LOAD)) begin
      n_fail++; $display("FAIL %s s_ready: got %b want %b", tag, strm_if.s_ready, m_mode == M_LOAD);
    end
    e_wr = 1'b0; e_err = 1'b0; e_tap = m_tap; nm = m_mode;
    case (m_mode)
      M_IDLE: begin
        if (cl) begin nm = M_CLEAR; m_cnt = 0; end
        else if (st) begin nm = M_LOAD; m_cnt = 0; end
      end
      M_LOAD: begin
        if (cl) begin
          e_err = 1'b1; nm = M_CLEAR; m_cnt = 0;
        end else begin
          if (st) begin e_err = 1'b1; m_cnt = 0; end
          if (v) begin
            e_wr = 1'b1; e_tap = d; m_cnt++;
            if (m_cnt == NTAPS) nm = M_DONE;
          end
        end
      end
      M_CLEAR: begin
        e_wr = 1'b1; e_tap = '0; m_cnt++;
        if (m_cnt == NTAPS) nm = M_DONE;
      end
      default: nm = M_IDLE;
    endcase
    m_mode = nm; m_tap = e_tap;
    @(posedge clk); #1;
    n_cmp++;
    if (tap_wr !== e_wr) begin n_fail++; $display("FAIL %s o_tap_wr: got %b want %b", tag, tap_wr, e_wr); end
    n_cmp++;
    if (tap !== e_tap) begin n_fail++; $display("FAIL %s o_tap: got %h want %h", tag, tap, e_tap); end
    n_cmp++;
    if (busy !== 1'(nm != M_IDLE)) begin n_fail++; $display("FAIL %s o_busy: got %b want %b", tag, busy, nm != M_IDLE); end
    n_cmp++;
    if (ce_hold !== 1'(nm != M_IDLE)) begin n_fail++; $display("FAIL %s o_ce_hold: got %b want %b", tag, ce_hold, nm != M_IDLE); end
    n_cmp++;
    if (done !== 1'(nm == M_DONE)) begin n_fail++; $display("FAIL %s o_done: got %b want %b", tag, done, nm == M_DONE); end
    n_cmp++;
    if (err !== e_err) begin n_fail++; $display("FAIL %s o_err: got %b want %b", tag, err, e_err); end
    if (tap_wr === 1'b1) begin
      obs_q.push_back(tap);
      for (int i = NTAPS - 1; i > 0; i--) chain[i] = chain[i-1];
      chain[0] = tap;
    end
    @(negedge clk);
  endtask

  task automatic begin_test(input string name);
    tag = name;
    obs_q.delete();
    sent_q.delete();
  endtask

  task automatic test_reset();
    begin_test("reset");
    rst_n = 1'b0;
    strm_if.s_valid = 1'b0; strm_if.s_tap = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({strm_if.s_ready, tap_wr, tap, ce_hold, busy, done, err} !== '0) begin
      n_fail++; $display("FAIL reset outputs: got %b want all 0",
                         {strm_if.s_ready, tap_wr, tap, ce_hold, busy, done, err});
    end
    rst_n = 1'b1;
    m_mode = M_IDLE; m_cnt = 0; m_tap = '0;
    step(0, 0, 0, '0);
  endtask

  task automatic test_load_b2b();
    logic [TW-1:0] v;
    begin_test("load_b2b");
    step(1, 0, 0, '0);
    for (int k = 0; k < NTAPS; k++) begin
      v = TW'($urandom);
      sent_q.push_back(v);
      step(0, 0, 1, v);
    end
    repeat (2) step(0, 0, 1, TW'($urandom));
    n_cmp++;
    if (obs_q.size() != NTAPS) begin n_fail++; $display("FAIL load_b2b count: got %0d want %0d", obs_q.size(), NTAPS); end
    for (int k = 0; k < NTAPS && k < obs_q.size(); k++) begin
      n_cmp++;
      if (obs_q[k] !== sent_q[k]) begin n_fail++; $display("FAIL load_b2b write%0d: got %h want %h", k, obs_q[k], sent_q[k]); end
      n_cmp++;
      if (chain[NTAPS-1-k] !== sent_q[k]) begin
        n_fail++; $display("FAIL load_b2b tap%0d: got %h want %h", NTAPS-1-k, chain[NTAPS-1-k], sent_q[k]);
      end
    end
  endtask

  task automatic test_load_gaps();
    logic [6:0]    pat;
    logic [TW-1:0] v;
    begin_test("load_gaps");
    pat = 7'b1011001;
    step(1, 0, 0, '0);
    for (int k = 0; k < 7; k++) begin
      v = TW'($urandom);
      if (pat[k]) sent_q.push_back(v);
      step(0, 0, pat[k], v);
    end
    step(0, 0, 0, '0);
    n_cmp++;
    if (obs_q.size() != NTAPS) begin n_fail++; $display("FAIL load_gaps count: got %0d want %0d", obs_q.size(), NTAPS); end
    for (int k = 0; k < NTAPS && k < obs_q.size(); k++) begin
      n_cmp++;
      if (obs_q[k] !== sent_q[k]) begin n_fail++; $display("FAIL load_gaps write%0d: got %h want %h", k, obs_q[k], sent_q[k]); end
    end
  endtask

  task automatic test_clear(input logic with_start);
    begin_test(with_start ? "start_and_clear" : "clear");
    step(with_start, 1, 1, 16'hbeef);
    for (int k = 0; k < NTAPS + 2; k++) step(0, 0, 1, TW'($urandom));
    n_cmp++;
    if (obs_q.size() != NTAPS) begin n_fail++; $display("FAIL %s count: got %0d want %0d", tag, obs_q.size(), NTAPS); end
    for (int k = 0; k < NTAPS; k++) begin
      n_cmp++;
      if (chain[k] !== '0) begin n_fail++; $display("FAIL %s tap%0d: got %h want 0000", tag, k, chain[k]); end
    end
  endtask

  task automatic test_abort_clear();
    begin_test("abort_clear");
    step(1, 0, 0, '0);
    step(0, 0, 1, TW'($urandom));
    step(0, 0, 1, TW'($urandom));
    obs_q.delete();
    step(0, 1, 1, 16'h1234);
    for (int k = 0; k < NTAPS + 1; k++) step(0, 0, 0, '0);
    n_cmp++;
    if (obs_q.size() != NTAPS) begin n_fail++; $display("FAIL abort_clear count: got %0d want %0d", obs_q.size(), NTAPS); end
  endtask

  task automatic test_abort_restart();
    logic [TW-1:0] v;
    begin_test("abort_restart");
    step(1, 0, 0, '0);
    step(0, 0, 1, TW'($urandom));
    step(0, 0, 1, TW'($urandom));
    obs_q.delete();
    step(1, 0, 0, '0);
    for (int k = 0; k < NTAPS; k++) begin
      v = TW'($urandom);
      sent_q.push_back(v);
      step(0, 0, 1, v);
    end
    step(0, 0, 0, '0);
    n_cmp++;
    if (obs_q.size() != NTAPS) begin n_fail++; $display("FAIL abort_restart count: got %0d want %0d", obs_q.size(), NTAPS); end
    for (int k = 0; k < NTAPS; k++) begin
      n_cmp++;
      if (chain[NTAPS-1-k] !== sent_q[k]) begin
        n_fail++; $display("FAIL abort_restart tap%0d: got %h want %h", NTAPS-1-k, chain[NTAPS-1-k], sent_q[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [TW-1:0] v;
    begin_test("async_reset");
    step(1, 0, 0, '0);
    step(0, 0, 1, TW'($urandom));
    step(0, 0, 1, TW'($urandom));
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({strm_if.s_ready, tap_wr, tap, ce_hold, busy, done, err} !== '0) begin
      n_fail++; $display("FAIL async_reset outputs: got %b want all 0",
                         {strm_if.s_ready, tap_wr, tap, ce_hold, busy, done, err});
    end
    m_mode = M_IDLE; m_cnt = 0; m_tap = '0;
    @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete();
    step(1, 0, 0, '0);
    for (int k = 0; k < NTAPS; k++) begin
      v = TW'($urandom);
      sent_q.push_back(v);
      step(0, 0, 1, v);
    end
    step(0, 0, 0, '0);
    n_cmp++;
    if (obs_q.size() != NTAPS) begin n_fail++; $display("FAIL async_reset count: got %0d want %0d", obs_q.size(), NTAPS); end
    for (int k = 0; k < NTAPS; k++) begin
      n_cmp++;
      if (chain[NTAPS-1-k] !== sent_q[k]) begin
        n_fail++; $display("FAIL async_reset tap%0d: got %h want %h", NTAPS-1-k, chain[NTAPS-1-k], sent_q[k]);
      end
    end
  endtask

  task automatic test_random();
    begin_test("random");
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 9) == 0), ($urandom_range(0, 24) == 0),
           1'($urandom), TW'($urandom));
    end
    repeat (NTAPS + 2) step(0, 0, 0, '0);
  endtask

  initial begin
    strm_if.s_valid = 1'b0;
    strm_if.s_tap   = '0;
    for (int i = 0; i < NTAPS; i++) chain[i] = '0;
    test_reset();
    test_load_b2b();
    test_load_gaps();
    test_clear(1'b0);
    test_abort_clear();
    test_abort_restart();
    test_clear(1'b1);
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
